// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in / serial-out shift transmitter with valid/ready load
module piso_shift_tx #(
  parameter int WIDTH      = 10,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             head;

  assign at_last = (cnt == CNT_LAST);
  assign head    = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  // Ready in IDLE, or on the final consumed bit so the next word follows with no gap
  assign load_ready = (state == IDLE) || (shift_en && at_last);

  // Serial outputs come only from registers; the line idles at IDLE_LEVEL
  assign busy       = (state == SHIFT);
  assign sout_valid = busy;
  assign sout       = busy ? head : IDLE_LEVEL;
  assign last       = busy && at_last;

  // Load / shift sequencer: captures a word, walks it out bit by bit, reloads back-to-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (!at_last) begin
              shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
              cnt   <= cnt + 1'b1;
            end else if (load_valid) begin
              shreg <= load_data;
              cnt   <= '0;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - directed self-checking bench for piso_shift_tx
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [9:0] load_data;
  logic       shift_en;

  logic ready0, sout0, sv0, last0, busy0;
  logic ready1, sout1, sv1, last1, busy1;

  logic [9:0] chain;
  int         total  = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(10), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready0),
    .load_data(load_data), .shift_en(shift_en), .sout(sout0), .sout_valid(sv0),
    .last(last0), .busy(busy0)
  );

  piso_shift_tx #(.WIDTH(10), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready1),
    .load_data(load_data), .shift_en(shift_en), .sout(sout1), .sout_valid(sv1),
    .last(last1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expects a just-accepted word on one instance, shift_en held high, 10 cycles
  task automatic expect_bits(input logic [9:0] w, input bit lsb, input string tag);
    for (int i = 0; i < 10; i++) begin
      logic eb;
      eb = lsb ? w[i] : w[9-i];
      #1;
      chk({tag, "_sout"},  lsb ? sout1 : sout0, eb);
      chk({tag, "_valid"}, lsb ? sv1 : sv0, 1'b1);
      chk({tag, "_last"},  lsb ? last1 : last0, (i == 9));
      chk({tag, "_ready"}, lsb ? ready1 : ready0, (i == 9));
      if (lsb) chain = {sout1, chain[9:1]};
      tick();
    end
  endtask

  initial begin
    logic [9:0] w;
    int j;

    // T1: reset held with load_valid high
    rst_n = 1'b0; load_valid = 1'b1; load_data = 10'h3FF; shift_en = 1'b1;
    chain = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t1_ready", ready0, 1'b1);
      chk("t1_sout",  sout0,  1'b0);
      chk("t1_valid", sv0,    1'b0);
      chk("t1_busy",  busy0,  1'b0);
      chk("t1_last",  last0,  1'b0);
      chk("t1_busy1", busy1,  1'b0);
    end
    rst_n = 1'b1; load_valid = 1'b0;
    tick();
    chk("t1_nocap", busy0, 1'b0);

    // T2: MSB-first word 1011001110
    w = 10'b1011001110;
    load_data = w; load_valid = 1'b1;
    #1;
    chk("t2_ready_idle", ready0, 1'b1);
    tick();
    load_valid = 1'b0;
    expect_bits(w, 1'b0, "t2");
    chk("t2_idle_busy", busy0, 1'b0);
    chk("t2_idle_sout", sout0, 1'b0);
    chk("t2_idle_rdy",  ready0, 1'b1);

    // T3: LSB-first 2A5 with loopback into a serial-in chain
    chain = '0;
    load_data = 10'h2A5; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_bits(10'h2A5, 1'b1, "t3");
    chk("t3_chain", chain, 10'h2A5);
    chk("t3_idle",  busy1, 1'b0);

    // T4: stall on cycles 3-5 of the word
    w = 10'h32B;
    load_data = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    j = 0;
    for (int c = 1; c <= 13; c++) begin
      shift_en = !(c >= 3 && c <= 5);
      #1;
      chk("t4_sout",  sout0,  w[9-j]);
      chk("t4_last",  last0,  (j == 9));
      chk("t4_ready", ready0, (j == 9) && shift_en);
      chk("t4_busy",  busy0,  1'b1);
      tick();
      if (shift_en) j++;
    end
    shift_en = 1'b1;
    #1;
    chk("t4_done", busy0, 1'b0);

    // T5: back-to-back 3FF then 000 with load_valid held
    load_data = 10'h3FF; load_valid = 1'b1;
    tick();
    load_data = 10'h000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_w1_sout",  sout0,  1'b1);
      chk("t5_w1_valid", sv0,    1'b1);
      chk("t5_w1_ready", ready0, (i == 9));
      tick();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_w2_sout",  sout0, 1'b0);
      chk("t5_w2_valid", sv0,   1'b1);
      chk("t5_w2_last",  last0, (i == 9));
      tick();
    end
    chk("t5_end_valid", sv0, 1'b0);

    // T6: reset after 4 bits, extra load attempts during SHIFT ignored
    w = 10'h38D;
    load_data = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i >= 1) begin
        load_valid = 1'b1; load_data = 10'h155;
      end
      #1;
      chk("t6_sout",  sout0,  w[9-i]);
      chk("t6_ready", ready0, 1'b0);
      tick();
    end
    rst_n = 1'b0; load_valid = 1'b0;
    tick();
    chk("t6_rst_busy",  busy0, 1'b0);
    chk("t6_rst_sout",  sout0, 1'b0);
    chk("t6_rst_valid", sv0,   1'b0);
    rst_n = 1'b1;
    tick();
    chk("t6_rel_busy", busy0, 1'b0);
    w = 10'h2C6;
    load_data = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    expect_bits(w, 1'b0, "t6_fresh");
    chk("t6_end_busy", busy0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
